// File: rtl/mpu6050_i2c_responder.sv
// mpu6050_i2c_responder: I2C target emulating the MPU6050 register map read by the accelerometer master.
// Optional MPU_RESP_GLITCH_FILTER_EN adds a 3-sample persistence filter on the synchronized SCL/SDA.
module mpu6050_i2c_responder #(
    parameter logic [6:0] I2C_ADDR     = 7'h68,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    output logic [7:0]  pwr_mgmt_1,
    output logic        wr_strobe,
    output logic        busy
);
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] ADDR     = 4'd1;
    localparam logic [3:0] ADDR_ACK = 4'd2;
    localparam logic [3:0] IGNORE   = 4'd3;
    localparam logic [3:0] PTR      = 4'd4;
    localparam logic [3:0] PTR_ACK  = 4'd5;
    localparam logic [3:0] WR_DATA  = 4'd6;
    localparam logic [3:0] WR_ACK   = 4'd7;
    localparam logic [3:0] RD_DATA  = 4'd8;
    localparam logic [3:0] RD_ACK   = 4'd9;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [1:0] raw, filt, prev;
    logic       scl, sda, scl_rise, scl_fall, start_ev, stop_ev;

    always_ff @(posedge clk)
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end

    assign raw = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

`ifdef MPU_RESP_GLITCH_FILTER_EN
    // A level is accepted once the current and two previous samples agree.
    for (genvar i = 0; i < 2; i++) begin : g_flt
        logic [1:0] h;
        logic       hold;
        assign filt[i] = (raw[i] == h[0] && raw[i] == h[1]) ? raw[i] : hold;
        always_ff @(posedge clk)
            if (rst) begin
                h    <= 2'b11;
                hold <= 1'b1;
            end else begin
                h    <= {h[0], raw[i]};
                hold <= filt[i];
            end
    end
`else
    assign filt = raw;
`endif

    always_ff @(posedge clk)
        if (rst) prev <= 2'b11;
        else prev <= filt;

    assign scl      = filt[1];
    assign sda      = filt[0];
    assign scl_rise = scl & ~prev[1];
    assign scl_fall = ~scl & prev[1];
    assign start_ev = scl & prev[1] & prev[0] & ~sda;
    assign stop_ev  = scl & prev[1] & ~prev[0] & sda;

    logic [3:0]  state, bit_cnt;
    logic [7:0]  shreg, ptr, rd_byte, in_byte;
    logic [47:0] shadow;
    logic        ack_phase, match;

    assign in_byte = {shreg[6:0], sda};
    assign match   = shreg[7:1] == I2C_ADDR;

    always_comb
        rd_byte = ptr == 8'h3B ? shadow[47:40] :
                  ptr == 8'h3C ? shadow[39:32] :
                  ptr == 8'h3D ? shadow[31:24] :
                  ptr == 8'h3E ? shadow[23:16] :
                  ptr == 8'h3F ? shadow[15:8]  :
                  ptr == 8'h40 ? shadow[7:0]   :
                  ptr == 8'h6B ? pwr_mgmt_1    :
                  ptr == 8'h75 ? WHO_AM_I_VAL  : 8'h00;

    // shreg holds the received byte in ADDR/PTR/WR_DATA and the outgoing byte in RD_DATA.
    always_ff @(posedge clk)
        if (rst) begin
            state      <= IDLE;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            pwr_mgmt_1 <= 8'h40;
            wr_strobe  <= 1'b0;
            ptr        <= 8'h00;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            ack_phase  <= 1'b0;
            shadow     <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_ev) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_ev) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WR_DATA:
                        if (scl_rise) begin
                            shreg   <= in_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                ack_phase <= 1'b0;
                                state     <= state == ADDR ? ADDR_ACK : state == PTR ? PTR_ACK : WR_ACK;
                                if (state == PTR) ptr <= in_byte;
                                if (state == WR_DATA) begin
                                    ptr <= ptr + 8'd1;
                                    if (ptr == 8'h6B) begin
                                        pwr_mgmt_1 <= in_byte;
                                        wr_strobe  <= 1'b1;
                                    end
                                end
                            end
                        end
                    ADDR_ACK:
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                if (match) begin
                                    sda_oe    <= 1'b1;
                                    busy      <= 1'b1;
                                    ack_phase <= 1'b1;
                                    if (shreg[0]) shadow <= {accel_x, accel_y, accel_z};
                                end else begin
                                    busy  <= 1'b0;
                                    state <= IGNORE;
                                end
                            end else if (shreg[0]) begin
                                state   <= RD_DATA;
                                bit_cnt <= 4'd0;
                                shreg   <= rd_byte;
                                sda_oe  <= ~rd_byte[7];
                            end else begin
                                state   <= PTR;
                                bit_cnt <= 4'd0;
                                sda_oe  <= 1'b0;
                            end
                        end
                    PTR_ACK, WR_ACK:
                        if (scl_fall) begin
                            sda_oe    <= ~ack_phase;
                            ack_phase <= 1'b1;
                            if (ack_phase) begin
                                state   <= WR_DATA;
                                bit_cnt <= 4'd0;
                            end
                        end
                    RD_DATA:
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe    <= 1'b0;
                                state     <= RD_ACK;
                                ack_phase <= 1'b0;
                            end else begin
                                sda_oe <= ~shreg[6];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    RD_ACK:
                        if (scl_rise) begin
                            ptr <= ptr + 8'd1;
                            if (sda) state <= IGNORE;
                            else ack_phase <= 1'b1;
                        end else if (scl_fall && ack_phase) begin
                            state   <= RD_DATA;
                            bit_cnt <= 4'd0;
                            shreg   <= rd_byte;
                            sda_oe  <= ~rd_byte[7];
                        end
                    default: ;
                endcase
            end
        end
endmodule
